// File: rtl/id_exe_reg_if.sv
// rtl/id_exe_reg_if.sv - ID/EXE pipeline register bundle: ID-side captures and EXE-side registered copies
interface id_exe_reg_if;
  logic [31:0] pc_in;
  logic [31:0] val_rn_in;
  logic [31:0] val_rm_in;
  logic [3:0]  dest_in;
  logic [3:0]  src1_in;
  logic [3:0]  src2_in;
  logic [3:0]  exe_cmd_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        wb_en_in;
  logic        b_in;
  logic        s_in;
  logic        imm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  status_in;

  logic [31:0] pc_out;
  logic [31:0] val_rn_out;
  logic [31:0] val_rm_out;
  logic [3:0]  dest_out;
  logic [3:0]  src1_out;
  logic [3:0]  src2_out;
  logic [3:0]  exe_cmd_out;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic        wb_en_out;
  logic        b_out;
  logic        s_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  status_out;
  logic        valid_out;
  logic [15:0] bubble_count;

  // The ID stage drives the *_in side and the EXE stage consumes the *_out side
  modport master (
    output pc_in, val_rn_in, val_rm_in, dest_in, src1_in, src2_in, exe_cmd_in,
           mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in,
           shift_operand_in, signed_imm_24_in, status_in,
    input  pc_out, val_rn_out, val_rm_out, dest_out, src1_out, src2_out, exe_cmd_out,
           mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
           shift_operand_out, signed_imm_24_out, status_out, valid_out, bubble_count
  );

  // The pipeline register itself sits on this side
  modport slave (
    input  pc_in, val_rn_in, val_rm_in, dest_in, src1_in, src2_in, exe_cmd_in,
           mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in, imm_in,
           shift_operand_in, signed_imm_24_in, status_in,
    output pc_out, val_rn_out, val_rm_out, dest_out, src1_out, src2_out, exe_cmd_out,
           mem_r_en_out, mem_w_en_out, wb_en_out, b_out, s_out, imm_out,
           shift_operand_out, signed_imm_24_out, status_out, valid_out, bubble_count
  );
endinterface

// File: rtl/id_exe_reg.sv
// rtl/id_exe_reg.sv - ID/EXE pipeline register with freeze, flush, hazard bubbles and bubble counter
module id_exe_reg (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               hazard,
  id_exe_reg_if.slave        bus
);

  // Bubble counter stops at all-ones instead of wrapping to zero
  logic [15:0] bubble_next;
  always_comb begin
    bubble_next = bus.bubble_count;
    if (bus.bubble_count != 16'hFFFF) begin
      bubble_next = bus.bubble_count + 16'd1;
    end
  end

  // Priority per edge: reset, freeze (hold all), flush (kill all), hazard (bubble control), load.
  // Every output comes straight from a flop so EXE sees stable operands all cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.pc_out            <= '0;
      bus.val_rn_out        <= '0;
      bus.val_rm_out        <= '0;
      bus.dest_out          <= '0;
      bus.src1_out          <= '0;
      bus.src2_out          <= '0;
      bus.exe_cmd_out       <= '0;
      bus.mem_r_en_out      <= 1'b0;
      bus.mem_w_en_out      <= 1'b0;
      bus.wb_en_out         <= 1'b0;
      bus.b_out             <= 1'b0;
      bus.s_out             <= 1'b0;
      bus.imm_out           <= 1'b0;
      bus.shift_operand_out <= '0;
      bus.signed_imm_24_out <= '0;
      bus.status_out        <= '0;
      bus.valid_out         <= 1'b0;
      bus.bubble_count      <= '0;
    end else if (!freeze) begin
      if (flush) begin
        // Branch taken: the captured instruction is wiped entirely
        bus.pc_out            <= '0;
        bus.val_rn_out        <= '0;
        bus.val_rm_out        <= '0;
        bus.dest_out          <= '0;
        bus.src1_out          <= '0;
        bus.src2_out          <= '0;
        bus.exe_cmd_out       <= '0;
        bus.mem_r_en_out      <= 1'b0;
        bus.mem_w_en_out      <= 1'b0;
        bus.wb_en_out         <= 1'b0;
        bus.b_out             <= 1'b0;
        bus.s_out             <= 1'b0;
        bus.imm_out           <= 1'b0;
        bus.shift_operand_out <= '0;
        bus.signed_imm_24_out <= '0;
        bus.status_out        <= '0;
        bus.valid_out         <= 1'b0;
        bus.bubble_count      <= bubble_next;
      end else begin
        // Data fields load on both normal and hazard edges
        bus.pc_out            <= bus.pc_in;
        bus.val_rn_out        <= bus.val_rn_in;
        bus.val_rm_out        <= bus.val_rm_in;
        bus.dest_out          <= bus.dest_in;
        bus.src1_out          <= bus.src1_in;
        bus.src2_out          <= bus.src2_in;
        bus.imm_out           <= bus.imm_in;
        bus.shift_operand_out <= bus.shift_operand_in;
        bus.signed_imm_24_out <= bus.signed_imm_24_in;
        bus.status_out        <= bus.status_in;
        if (hazard) begin
          // Bubble: no side effects downstream, flagged invalid
          bus.exe_cmd_out  <= '0;
          bus.mem_r_en_out <= 1'b0;
          bus.mem_w_en_out <= 1'b0;
          bus.wb_en_out    <= 1'b0;
          bus.b_out        <= 1'b0;
          bus.s_out        <= 1'b0;
          bus.valid_out    <= 1'b0;
          bus.bubble_count <= bubble_next;
        end else begin
          bus.exe_cmd_out  <= bus.exe_cmd_in;
          bus.mem_r_en_out <= bus.mem_r_en_in;
          bus.mem_w_en_out <= bus.mem_w_en_in;
          bus.wb_en_out    <= bus.wb_en_in;
          bus.b_out        <= bus.b_in;
          bus.s_out        <= bus.s_in;
          bus.valid_out    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_exe_reg.sv
// tb/tb_id_exe_reg.sv - table-driven bench for the ID/EXE pipeline register
module tb_id_exe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exe_cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb;
    logic        b;
    logic        s;
    logic        imm;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [3:0]  status;
  } payload_t;

  typedef struct packed {
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        hazard;
    payload_t    din;
    payload_t    exp;
    logic        exp_valid;
    logic [15:0] exp_count;
  } vec_t;

  logic clk;
  logic rst;
  logic freeze;
  logic flush;
  logic hazard;
  id_exe_reg_if bus ();

  id_exe_reg dut (
    .clk    (clk),
    .rst    (rst),
    .freeze (freeze),
    .flush  (flush),
    .hazard (hazard),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int fails;

  task automatic drive(input payload_t p);
    bus.pc_in            = p.pc;
    bus.val_rn_in        = p.val_rn;
    bus.val_rm_in        = p.val_rm;
    bus.dest_in          = p.dest;
    bus.src1_in          = p.src1;
    bus.src2_in          = p.src2;
    bus.exe_cmd_in       = p.exe_cmd;
    bus.mem_r_en_in      = p.mem_r;
    bus.mem_w_en_in      = p.mem_w;
    bus.wb_en_in         = p.wb;
    bus.b_in             = p.b;
    bus.s_in             = p.s;
    bus.imm_in           = p.imm;
    bus.shift_operand_in = p.shift;
    bus.signed_imm_24_in = p.simm;
    bus.status_in        = p.status;
  endtask

  function automatic payload_t capture();
    payload_t p;
    p.pc      = bus.pc_out;
    p.val_rn  = bus.val_rn_out;
    p.val_rm  = bus.val_rm_out;
    p.dest    = bus.dest_out;
    p.src1    = bus.src1_out;
    p.src2    = bus.src2_out;
    p.exe_cmd = bus.exe_cmd_out;
    p.mem_r   = bus.mem_r_en_out;
    p.mem_w   = bus.mem_w_en_out;
    p.wb      = bus.wb_en_out;
    p.b       = bus.b_out;
    p.s       = bus.s_out;
    p.imm     = bus.imm_out;
    p.shift   = bus.shift_operand_out;
    p.simm    = bus.signed_imm_24_out;
    p.status  = bus.status_out;
    return p;
  endfunction

  // Expected image of a hazard bubble: data kept, ALU command and enables dropped
  function automatic payload_t bubbled(input payload_t p);
    payload_t q;
    q = p;
    q.exe_cmd = 4'h0;
    q.mem_r   = 1'b0;
    q.mem_w   = 1'b0;
    q.wb      = 1'b0;
    q.b       = 1'b0;
    q.s       = 1'b0;
    return q;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic fr, input logic fl, input logic hz,
                              input payload_t din, input payload_t exp,
                              input logic ev, input logic [15:0] ec);
    vec_t v;
    v.rst = r; v.freeze = fr; v.flush = fl; v.hazard = hz;
    v.din = din; v.exp = exp; v.exp_valid = ev; v.exp_count = ec;
    return v;
  endfunction

  payload_t zero_p, pl, p20, p24, pf, ph, pa;
  vec_t vecs[14];

  initial begin
    checks = 0;
    fails  = 0;

    zero_p = '0;

    pl = '0;
    pl.pc = 32'h0000_0010; pl.val_rm = 32'h0000_00FF; pl.imm = 1'b0;
    pl.shift = 12'h083; pl.wb = 1'b1;

    p20 = '0;
    p20.pc = 32'h0000_0020; p20.val_rn = 32'h1234_5678; p20.dest = 4'h5; p20.src1 = 4'h1;
    p20.src2 = 4'h2; p20.exe_cmd = 4'h4; p20.mem_r = 1'b1; p20.wb = 1'b1; p20.s = 1'b1;
    p20.imm = 1'b1; p20.shift = 12'hABC; p20.simm = 24'h80_0001; p20.status = 4'h6;

    p24 = '0;
    p24.pc = 32'h0000_0024; p24.val_rm = 32'hCAFE_0000; p24.b = 1'b1; p24.exe_cmd = 4'h9;

    pf = '0;
    pf.pc = 32'h0000_0028; pf.wb = 1'b1; pf.mem_w = 1'b1; pf.dest = 4'hA; pf.val_rm = 32'h55;

    ph = '0;
    ph.pc = 32'h0000_0030; ph.val_rn = 32'hDEAD_BEEF; ph.mem_r = 1'b1; ph.exe_cmd = 4'h2;
    ph.dest = 4'h3; ph.status = 4'hA; ph.b = 1'b1; ph.s = 1'b1; ph.shift = 12'hFFF;
    ph.simm = 24'hFF_FFFE; ph.imm = 1'b1;

    pa = '1;

    //            rst fr fl hz  din  expected          valid count
    vecs[0]  = mk(0,  0, 0, 0, pa,  zero_p,           0, 16'd0);
    vecs[1]  = mk(1,  0, 0, 0, pl,  pl,               1, 16'd0);
    vecs[2]  = mk(1,  0, 0, 0, p20, p20,              1, 16'd0);
    vecs[3]  = mk(1,  1, 1, 0, p24, p20,              1, 16'd0);
    vecs[4]  = mk(1,  1, 1, 0, p24, p20,              1, 16'd0);
    vecs[5]  = mk(1,  1, 1, 0, p24, p20,              1, 16'd0);
    vecs[6]  = mk(1,  0, 1, 0, pf,  zero_p,           0, 16'd1);
    vecs[7]  = mk(1,  0, 0, 1, ph,  bubbled(ph),      0, 16'd2);
    vecs[8]  = mk(1,  0, 1, 1, ph,  zero_p,           0, 16'd3);
    vecs[9]  = mk(1,  0, 0, 0, pa,  pa,               1, 16'd3);
    vecs[10] = mk(1,  1, 0, 1, ph,  pa,               1, 16'd3);
    vecs[11] = mk(1,  0, 0, 1, pl,  bubbled(pl),      0, 16'd4);
    vecs[12] = mk(0,  1, 1, 1, p20, zero_p,           0, 16'd0);
    vecs[13] = mk(1,  0, 0, 0, p24, p24,              1, 16'd0);

    for (int i = 0; i < 14; i++) begin
      rst    = vecs[i].rst;
      freeze = vecs[i].freeze;
      flush  = vecs[i].flush;
      hazard = vecs[i].hazard;
      drive(vecs[i].din);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_payload", i), 160'(capture()), 160'(vecs[i].exp));
      check($sformatf("v%0d_valid", i), 160'(bus.valid_out), 160'(vecs[i].exp_valid));
      check($sformatf("v%0d_count", i), 160'(bus.bubble_count), 160'(vecs[i].exp_count));
    end

    // Long hazard run from a zero count: just below the ceiling, then pinned at it
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b1;
    drive(ph);
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    check("sat_below", 160'(bus.bubble_count), 160'(16'hFFFE));
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1;
    check("sat_hold", 160'(bus.bubble_count), 160'(16'hFFFF));
    check("sat_valid", 160'(bus.valid_out), 160'(1'b0));

    // Reset wins over freeze and clears everything including the counter
    rst = 1'b0; freeze = 1'b1; flush = 1'b1; hazard = 1'b1;
    @(posedge clk);
    #1;
    check("rst_frz_payload", 160'(capture()), 160'(zero_p));
    check("rst_frz_valid", 160'(bus.valid_out), 160'(1'b0));
    check("rst_frz_count", 160'(bus.bubble_count), 160'(16'h0000));

    // First edge out of reset loads with exactly one cycle of latency
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
    drive(pl);
    @(posedge clk);
    #1;
    check("post_rst_load", 160'(capture()), 160'(pl));
    check("post_rst_valid", 160'(bus.valid_out), 160'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
